// File: rtl/car_parking_pkg.sv
// Shared state codes and configuration defaults for the car-park entry controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: state_t (IDLE=00, GATE_OPEN=01, PARKED=10, FULL=11), CP_TIMEOUT_DEFAULT, CP_CNT_W_DEFAULT.
package car_parking_pkg;

    // All four codes are legal states, so no encoding can lock up the FSM.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_GATE_OPEN = 2'b01,
        ST_PARKED    = 2'b10,
        ST_FULL      = 2'b11
    } state_t;

    localparam int CP_TIMEOUT_DEFAULT = 16;
    localparam int CP_CNT_W_DEFAULT   = 5;

endpackage

// File: rtl/car_parking_if.sv
// Entry-lane signal bundle: sensor and slot lamps in, 2-bit status out.
// Latency: n/a (wires only).
// Backpressure: none; level signals sampled every clock.
// Signals: sn (car sensor), gL (slot free), rL (park full), status (registered state code).
interface car_parking_if;

    logic       sn;
    logic       gL;
    logic       rL;
    logic [1:0] status;

    // master: lane sensors / test driver side
    modport master (output sn, output gL, output rL, input status);
    // slave: the controller
    modport slave  (input sn, input gL, input rL, output status);

endinterface

// File: rtl/cp_gate_timer.sv
// Counts cycles spent with the gate open and flags when the limit is reached.
// Latency: o_expired is combinational from the count register; asserts on the LIMIT-th enabled cycle.
// Backpressure: none.
// Ports: i_clk, i_rst_n (async active-low), i_clr (sync clear, dominant), i_en (count), o_expired.
module cp_gate_timer
    import car_parking_pkg::*;
#(
    parameter int CNT_W = CP_CNT_W_DEFAULT,
    parameter int LIMIT = CP_TIMEOUT_DEFAULT
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    logic [CNT_W-1:0] r_cnt;

    // Count k holds during the (k+1)-th enabled cycle, so the flag rises on cycle LIMIT.
    assign o_expired = i_en && (r_cnt == CNT_W'(LIMIT - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_expired) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/car_parking_ctrl.sv
// Single-gate car-park entry controller: sensor opens gate, lamps decide PARKED or FULL.
// Latency: status changes one clock edge after inputs are sampled; no comb input->output path.
// Backpressure: none; inputs are levels evaluated every clock.
// Ports: clk, rst (async active-low), cp_if (slave: sn, gL, rL in; status out).
// Optional gate timeout enabled by defining CP_GATE_TIMEOUT_EN.
module car_parking_ctrl
    import car_parking_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = CP_TIMEOUT_DEFAULT,
    parameter int CNT_W          = CP_CNT_W_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    car_parking_if.slave   cp_if
);

    state_t r_state;
    logic   w_timeout;

`ifdef CP_GATE_TIMEOUT_EN
    // Held clear outside GATE_OPEN, so the count always starts at zero on entry.
    cp_gate_timer #(
        .CNT_W (CNT_W),
        .LIMIT (TIMEOUT_CYCLES)
    ) u_gate_timer (
        .i_clk     (clk),
        .i_rst_n   (rst),
        .i_clr     (r_state != ST_GATE_OPEN),
        .i_en      (r_state == ST_GATE_OPEN),
        .o_expired (w_timeout)
    );
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (TIMEOUT_CYCLES > CNT_W);
    assign w_timeout    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cp_if.sn) r_state <= ST_GATE_OPEN;
                end
                ST_GATE_OPEN: begin
                    // Lamps outrank the timeout; rL outranks gL.
                    if (cp_if.rL)      r_state <= ST_FULL;
                    else if (cp_if.gL) r_state <= ST_PARKED;
                    else if (w_timeout) r_state <= ST_IDLE;
                end
                ST_PARKED, ST_FULL: begin
                    if (!cp_if.sn && !cp_if.gL && !cp_if.rL) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cp_if.status = r_state;

endmodule

// File: tb/tb_car_parking_ctrl.sv
// Directed bench for car_parking_ctrl: inputs change on negedge, status sampled 1 ns after posedge.
// Latency: n/a.
// Backpressure: n/a.
module tb_car_parking_ctrl;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_miss;

    car_parking_if cp_if();

    car_parking_ctrl #(
        .TIMEOUT_CYCLES (4),
        .CNT_W          (5)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .cp_if (cp_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input logic [1:0] exp, input string tag);
        n_vec++;
        assert (cp_if.status === exp) else begin
            n_miss++;
            $error("FAIL %s: status=%b expected=%b", tag, cp_if.status, exp);
        end
    endtask

    // Called at a negedge: apply inputs, take one rising edge, check, return at next negedge.
    task automatic step(input logic s, input logic g, input logic r,
                        input logic [1:0] exp, input string tag);
        cp_if.sn = s;
        cp_if.gL = g;
        cp_if.rL = r;
        @(posedge clk);
        #1;
        chk(exp, tag);
        @(negedge clk);
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;

        // Reset with sensor and lamp active: status forced to 00 and held.
        rst      = 1'b0;
        cp_if.sn = 1'b1;
        cp_if.gL = 1'b1;
        cp_if.rL = 1'b0;
        #2;
        chk(2'b00, "reset_async");
        @(posedge clk);
        @(posedge clk);
        #1;
        chk(2'b00, "reset_held");
        @(negedge clk);
        rst = 1'b1;

        // Park sequence; IDLE ignores the lamps.
        step(1'b0, 1'b0, 1'b0, 2'b00, "idle_quiet");
        step(1'b0, 1'b1, 1'b1, 2'b00, "idle_ignores_lamps");
        step(1'b1, 1'b0, 1'b0, 2'b01, "open_on_sn");
        step(1'b0, 1'b0, 1'b0, 2'b01, "open_sn_drop");
        step(1'b0, 1'b1, 1'b0, 2'b10, "open_to_parked");
        step(1'b0, 1'b1, 1'b0, 2'b10, "parked_hold_gl");
        step(1'b1, 1'b0, 1'b0, 2'b10, "parked_hold_sn");
        step(1'b0, 1'b0, 1'b1, 2'b10, "parked_hold_rl");
        step(1'b0, 1'b0, 1'b0, 2'b00, "parked_return");

        // Full sequence.
        step(1'b1, 1'b0, 1'b0, 2'b01, "open2");
        step(1'b0, 1'b0, 1'b1, 2'b11, "open_to_full");
        step(1'b0, 1'b0, 1'b1, 2'b11, "full_hold_rl");
        step(1'b1, 1'b0, 1'b0, 2'b11, "full_hold_sn");
        step(1'b0, 1'b1, 1'b0, 2'b11, "full_hold_gl");
        step(1'b0, 1'b0, 1'b0, 2'b00, "full_return");

        // Both lamps in GATE_OPEN: rL wins.
        step(1'b1, 1'b0, 1'b0, 2'b01, "open3");
        step(1'b0, 1'b1, 1'b1, 2'b11, "rl_priority");
        step(1'b0, 1'b0, 1'b0, 2'b00, "full_return2");

        // Reset mid-operation while PARKED.
        step(1'b1, 1'b0, 1'b0, 2'b01, "open4");
        step(1'b0, 1'b1, 1'b0, 2'b10, "parked2");
        #2;
        rst = 1'b0;
        #1;
        chk(2'b00, "midop_reset_async");
        @(posedge clk);
        #1;
        chk(2'b00, "midop_reset_held");
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, 1'b1, 1'b0, 2'b01, "release_sn_high");

        // Gate left open with no lamps (entered GATE_OPEN on the previous edge).
`ifdef CP_GATE_TIMEOUT_EN
        step(1'b0, 1'b0, 1'b0, 2'b01, "to_cycle1");
        step(1'b0, 1'b0, 1'b0, 2'b01, "to_cycle2");
        step(1'b0, 1'b0, 1'b0, 2'b01, "to_cycle3");
        step(1'b0, 1'b0, 1'b0, 2'b00, "to_expire");
        step(1'b0, 1'b0, 1'b0, 2'b00, "to_idle_stay");
        step(1'b1, 1'b0, 1'b0, 2'b01, "to_reopen");
`else
        for (int i = 0; i < 22; i++) begin
            step(1'b0, 1'b0, 1'b0, 2'b01, "no_timeout_wait");
        end
`endif
        // gL on the would-be timeout cycle takes priority.
        step(1'b0, 1'b0, 1'b0, 2'b01, "pri_cycle1");
        step(1'b0, 1'b0, 1'b0, 2'b01, "pri_cycle2");
        step(1'b0, 1'b0, 1'b0, 2'b01, "pri_cycle3");
        step(1'b0, 1'b1, 1'b0, 2'b10, "pri_gl_on_timeout");
        step(1'b0, 1'b0, 1'b0, 2'b00, "final_return");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
